// File: rtl/qq_router_sequencer_if.sv
// ============================================================================
// Module      : qq_router_sequencer_if
// Description : Host handshake, valueRouter and BRAM signal bundle for the
//               QuickQ router sequencer. QQ_STATS_EN adds statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qq_router_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    // host side
    logic              enq_i;
    logic [DATA_W-1:0] enq_data_i;
    logic              enq_rdy_o;
    logic              deq_i;
    logic              deq_vld_o;
    logic [DATA_W-1:0] deq_data_o;
    logic              deq_err_o;
    logic              full_o;
    logic              empty_o;
    // router side
    logic [2:0]        mode_o;
    logic [31:0]       array_cnt_o;
    logic [DATA_W-1:0] reg_out_o;
    logic [31:0]       array_size_o;
    logic [DATA_W-1:0] bram_insert_i;
    logic [DATA_W-1:0] to_register_i;
    logic [31:0]       array_cnt_i;
    logic [31:0]       last_addr_i;
    logic              done_i;
    // BRAM side
    logic [ADDR_W-1:0] bram_addr_o;
    logic              bram_we_o;
    logic [DATA_W-1:0] bram_wdata_o;
`ifdef QQ_STATS_EN
    logic [31:0]       peak_cnt_o;
    logic [31:0]       op_cnt_o;
`endif

    modport slave (
        input  enq_i, enq_data_i, deq_i,
        input  bram_insert_i, to_register_i, array_cnt_i, last_addr_i, done_i,
        output enq_rdy_o, deq_vld_o, deq_data_o, deq_err_o, full_o, empty_o,
        output mode_o, array_cnt_o, reg_out_o, array_size_o,
`ifdef QQ_STATS_EN
        output peak_cnt_o, op_cnt_o,
`endif
        output bram_addr_o, bram_we_o, bram_wdata_o
    );

    modport master (
        output enq_i, enq_data_i, deq_i,
        output bram_insert_i, to_register_i, array_cnt_i, last_addr_i, done_i,
        input  enq_rdy_o, deq_vld_o, deq_data_o, deq_err_o, full_o, empty_o,
        input  mode_o, array_cnt_o, reg_out_o, array_size_o,
`ifdef QQ_STATS_EN
        input  peak_cnt_o, op_cnt_o,
`endif
        input  bram_addr_o, bram_we_o, bram_wdata_o
    );
endinterface

`default_nettype wire

// File: rtl/qq_router_sequencer.sv
// ============================================================================
// Module      : qq_router_sequencer
// Description : FSM driving the QuickQ valueRouter and its single-port BRAM as
//               a sorted min-queue. Optional macro QQ_STATS_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qq_router_sequencer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qq_router_sequencer_if.slave bus
);
    localparam logic [3:0] c_st_clear    = 4'd0;
    localparam logic [3:0] c_st_idle     = 4'd1;
    localparam logic [3:0] c_st_enq_rd   = 4'd2;
    localparam logic [3:0] c_st_enq_cmp  = 4'd3;
    localparam logic [3:0] c_st_enq_inc  = 4'd4;
    localparam logic [3:0] c_st_deq_rd   = 4'd5;
    localparam logic [3:0] c_st_deq_head = 4'd6;
    localparam logic [3:0] c_st_deq_last = 4'd7;
    localparam logic [3:0] c_st_sh_rd    = 4'd8;
    localparam logic [3:0] c_st_sh_wr    = 4'd9;
    localparam logic [3:0] c_st_deq_clr  = 4'd10;
    localparam logic [3:0] c_st_deq_dec  = 4'd11;

    localparam logic [2:0] c_mode_ins  = 3'b000;
    localparam logic [2:0] c_mode_inc  = 3'b001;
    localparam logic [2:0] c_mode_last = 3'b010;
    localparam logic [2:0] c_mode_rem  = 3'b011;
    localparam logic [2:0] c_mode_dec  = 3'b100;

    localparam logic [DATA_W-1:0] c_ones      = {DATA_W{1'b1}};
    localparam logic [31:0]       c_depth     = 32'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last_slot = ADDR_W'(DEPTH - 1);

    logic [3:0]        r_state;
    logic [31:0]       r_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_last;
    logic [DATA_W-1:0] r_reg;
    logic [DATA_W-1:0] r_deq_data;
    logic              r_deq_err;
    logic              r_arm;

    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_cnt_sat;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] w_cnt_m1;
    logic [ADDR_W-1:0] w_last;
    logic              w_ptr_lt_cnt;
    logic [2:0]        w_mode;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic              w_unused;

    assign w_full       = (r_cnt == c_depth);
    assign w_empty      = (r_cnt == 32'd0);
    assign w_cnt_sat    = (bus.array_cnt_i > c_depth) ? c_depth : bus.array_cnt_i;
    assign w_ptr_nxt    = r_ptr + ADDR_W'(1);
    assign w_cnt_m1     = ADDR_W'(r_cnt - 32'd1);
    assign w_ptr_lt_cnt = (32'(r_ptr) < r_cnt);
    // The walk is bounded by our own count even if the router reports nonsense.
    assign w_last       = (bus.last_addr_i < r_cnt) ? bus.last_addr_i[ADDR_W-1:0] : w_cnt_m1;
    assign w_unused     = bus.done_i;

    always_comb begin
        w_mode  = c_mode_ins;
        w_addr  = '0;
        w_we    = 1'b0;
        w_wdata = c_ones;
        case (r_state)
            c_st_clear: begin
                w_addr = r_ptr;
                w_we   = r_arm;
            end
            c_st_enq_rd:   w_addr = r_ptr;
            c_st_enq_cmp: begin
                w_addr  = r_ptr;
                w_we    = 1'b1;
                w_wdata = bus.bram_insert_i;
            end
            c_st_enq_inc:  w_mode = c_mode_inc;
            c_st_deq_head: w_mode = c_mode_rem;
            c_st_deq_last: w_mode = c_mode_last;
            c_st_sh_rd:    w_addr = w_ptr_nxt;
            c_st_sh_wr: begin
                w_mode  = c_mode_rem;
                w_addr  = r_ptr;
                w_we    = 1'b1;
                w_wdata = bus.bram_insert_i;
            end
            c_st_deq_clr: begin
                w_addr = r_last;
                w_we   = 1'b1;
            end
            c_st_deq_dec:  w_mode = c_mode_dec;
            default: ;
        endcase
    end

    // r_arm holds off the first wipe write until reset has been released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_clear;
            r_cnt      <= 32'd0;
            r_ptr      <= '0;
            r_last     <= '0;
            r_reg      <= '0;
            r_deq_data <= '0;
            r_deq_err  <= 1'b0;
            r_arm      <= 1'b0;
        end else begin
            r_deq_err <= 1'b0;
            r_arm     <= 1'b1;
            case (r_state)
                c_st_clear: begin
                    if (r_arm) begin
                        if (r_ptr == c_last_slot) begin
                            r_ptr   <= '0;
                            r_state <= c_st_idle;
                        end else begin
                            r_ptr <= w_ptr_nxt;
                        end
                    end
                end
                c_st_idle: begin
                    if (bus.deq_i) begin
                        if (w_empty) begin
                            r_deq_err <= 1'b1;
                        end else begin
                            r_ptr   <= '0;
                            r_state <= c_st_deq_rd;
                        end
                    end else if (bus.enq_i && !w_full) begin
                        r_reg   <= bus.enq_data_i;
                        r_ptr   <= '0;
                        r_state <= c_st_enq_rd;
                    end
                end
                c_st_enq_rd: r_state <= c_st_enq_cmp;
                c_st_enq_cmp: begin
                    r_reg <= bus.to_register_i;
                    if (w_ptr_lt_cnt) begin
                        r_ptr   <= w_ptr_nxt;
                        r_state <= c_st_enq_rd;
                    end else begin
                        r_state <= c_st_enq_inc;
                    end
                end
                c_st_enq_inc: begin
                    r_cnt   <= w_cnt_sat;
                    r_state <= c_st_idle;
                end
                c_st_deq_rd: r_state <= c_st_deq_head;
                c_st_deq_head: begin
                    r_deq_data <= bus.bram_insert_i;
                    r_state    <= c_st_deq_last;
                end
                c_st_deq_last: begin
                    r_last  <= w_last;
                    r_ptr   <= '0;
                    r_state <= (w_last == '0) ? c_st_deq_clr : c_st_sh_rd;
                end
                c_st_sh_rd: r_state <= c_st_sh_wr;
                c_st_sh_wr: begin
                    r_ptr   <= w_ptr_nxt;
                    r_state <= (w_ptr_nxt == r_last) ? c_st_deq_clr : c_st_sh_rd;
                end
                c_st_deq_clr: r_state <= c_st_deq_dec;
                c_st_deq_dec: begin
                    r_cnt   <= w_cnt_sat;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_ptr   <= '0;
                    r_state <= c_st_clear;
                end
            endcase
        end
    end

`ifdef QQ_STATS_EN
    logic [31:0] r_peak_cnt;
    logic [31:0] r_op_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_cnt <= 32'd0;
            r_op_cnt   <= 32'd0;
        end else begin
            if (r_cnt > r_peak_cnt)
                r_peak_cnt <= r_cnt;
            if ((r_state == c_st_enq_inc) || (r_state == c_st_deq_dec))
                r_op_cnt <= r_op_cnt + 32'd1;
        end
    end

    assign bus.peak_cnt_o = r_peak_cnt;
    assign bus.op_cnt_o   = r_op_cnt;
`endif

    assign bus.enq_rdy_o    = (r_state == c_st_idle) && !w_full;
    assign bus.deq_vld_o    = (r_state == c_st_deq_dec);
    assign bus.deq_data_o   = r_deq_data;
    assign bus.deq_err_o    = r_deq_err;
    assign bus.full_o       = w_full;
    assign bus.empty_o      = w_empty;
    assign bus.mode_o       = w_mode;
    assign bus.array_cnt_o  = r_cnt;
    assign bus.reg_out_o    = r_reg;
    assign bus.array_size_o = c_depth;
    assign bus.bram_addr_o  = w_addr;
    assign bus.bram_we_o    = w_we;
    assign bus.bram_wdata_o = w_wdata;

endmodule

`default_nettype wire

// File: tb/tb_qq_router_sequencer.sv
// ============================================================================
// Module      : tb_qq_router_sequencer
// Description : Directed bench for qq_router_sequencer with a behavioural
//               valueRouter and single-port BRAM around the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qq_router_sequencer;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 5;
    localparam int          ADDR_W = 3;
    localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;
    int   inc_seen = 0;
    int   vld_seen = 0;
    int   err_seen = 0;
    logic [31:0] vld_data = '0;

    always #5 clk = ~clk;

    qq_router_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    qq_router_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // single-port BRAM, one-cycle read latency
    logic [31:0] mem [0:7];
    logic [31:0] rdata;
    always @(posedge clk) begin
        if (bus.bram_we_o) mem[bus.bram_addr_o] <= bus.bram_wdata_o;
        rdata <= mem[bus.bram_addr_o];
    end

    // valueRouter: min of (slot, carried) stays, max moves on
    always_comb begin
        bus.bram_insert_i = rdata;
        bus.to_register_i = bus.reg_out_o;
        bus.array_cnt_i   = bus.array_cnt_o;
        bus.last_addr_i   = bus.array_cnt_o - 32'd1;
        bus.done_i        = 1'b0;
        case (bus.mode_o)
            3'b000: begin
                if (rdata <= bus.reg_out_o) begin
                    bus.bram_insert_i = rdata;
                    bus.to_register_i = bus.reg_out_o;
                end else begin
                    bus.bram_insert_i = bus.reg_out_o;
                    bus.to_register_i = rdata;
                end
            end
            3'b001: bus.array_cnt_i = bus.array_cnt_o + 32'd1;
            3'b100: bus.array_cnt_i = bus.array_cnt_o - 32'd1;
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mode_o == 3'b001) inc_seen++;
            if (bus.deq_vld_o) begin
                vld_seen++;
                vld_data = bus.deq_data_o;
            end
            if (bus.deq_err_o) err_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_enq(input logic [31:0] v);
        @(negedge clk);
        bus.enq_i      = 1'b1;
        bus.enq_data_i = v;
        @(negedge clk);
        bus.enq_i      = 1'b0;
        wait_cyc(16);
    endtask

    task automatic do_deq();
        @(negedge clk);
        bus.deq_i = 1'b1;
        @(negedge clk);
        bus.deq_i = 1'b0;
        wait_cyc(20);
    endtask

    // called at a negedge with rst_n just released
    task automatic clear_seq();
        @(posedge clk);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            check("clr_we",   32'(bus.bram_we_o), 32'd1);
            check("clr_addr", 32'(bus.bram_addr_o), 32'(k));
            check("clr_data", bus.bram_wdata_o, ONES);
            check("clr_rdy",  32'(bus.enq_rdy_o), 32'd0);
        end
        @(negedge clk);
        check("clr_done_rdy",   32'(bus.enq_rdy_o), 32'd1);
        check("clr_done_empty", 32'(bus.empty_o), 32'd1);
        for (int k = 0; k < DEPTH; k++) check("clr_mem", mem[k], ONES);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_q [4];
        logic        found;
        exp_q[0] = 32'h0000_0002;
        exp_q[1] = 32'h39B0_34AC;
        exp_q[2] = 32'hF657_C062;
        exp_q[3] = 32'hF680_D628;
        bus.enq_i      = 1'b0;
        bus.enq_data_i = '0;
        bus.deq_i      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_mode",  32'(bus.mode_o), 32'd0);
        check("rst_we",    32'(bus.bram_we_o), 32'd0);
        check("rst_reg",   bus.reg_out_o, 32'd0);
        check("rst_deq",   bus.deq_data_o, 32'd0);
        check("rst_rdy",   32'(bus.enq_rdy_o), 32'd0);
        check("rst_cnt",   bus.array_cnt_o, 32'd0);
        check("rst_size",  bus.array_size_o, 32'd5);
        check("rst_vld",   32'(bus.deq_vld_o), 32'd0);
`ifdef QQ_STATS_EN
        check("rst_op",    bus.op_cnt_o, 32'd0);
`endif
        rst_n = 1'b1;
        clear_seq();

        do_enq(32'd2);
        check("enq2_inc", 32'(inc_seen), 32'd1);
        do_enq(32'd1);
        check("enq1_inc",  32'(inc_seen), 32'd2);
        check("enq1_mem0", mem[0], 32'd1);
        check("enq1_mem1", mem[1], 32'd2);
        check("enq1_mem2", mem[2], ONES);
        check("enq1_cnt",  bus.array_cnt_o, 32'd2);

        do_enq(32'hF680_D628);
        do_enq(32'hF657_C062);
        do_enq(32'h39B0_34AC);
        check("full_full", 32'(bus.full_o), 32'd1);
        check("full_rdy",  32'(bus.enq_rdy_o), 32'd0);
        check("full_cnt",  bus.array_cnt_o, 32'd5);
        do_enq(32'd0);
        check("ign_cnt",  bus.array_cnt_o, 32'd5);
        check("ign_inc",  32'(inc_seen), 32'd5);
        check("ign_mem0", mem[0], 32'd1);

        do_deq();
        check("deq_vld",  32'(vld_seen), 32'd1);
        check("deq_data", vld_data, 32'd1);
        check("deq_mem0", mem[0], 32'h0000_0002);
        check("deq_mem1", mem[1], 32'h39B0_34AC);
        check("deq_mem2", mem[2], 32'hF657_C062);
        check("deq_mem3", mem[3], 32'hF680_D628);
        check("deq_mem4", mem[4], ONES);
        check("deq_cnt",  bus.array_cnt_o, 32'd4);
        check("deq_full", 32'(bus.full_o), 32'd0);
`ifdef QQ_STATS_EN
        check("st_op",   bus.op_cnt_o, 32'd6);
        check("st_peak", bus.peak_cnt_o, 32'd5);
`endif

        for (int i = 0; i < 4; i++) begin
            do_deq();
            check("drain_data", vld_data, exp_q[i]);
        end
        check("drain_vld",   32'(vld_seen), 32'd5);
        check("drain_empty", 32'(bus.empty_o), 32'd1);
        check("drain_mem0",  mem[0], ONES);

        @(negedge clk);
        bus.deq_i      = 1'b1;
        bus.enq_i      = 1'b1;
        bus.enq_data_i = 32'd7;
        @(negedge clk);
        bus.deq_i = 1'b0;
        bus.enq_i = 1'b0;
        wait_cyc(4);
        check("both_err",   32'(err_seen), 32'd1);
        check("both_cnt",   bus.array_cnt_o, 32'd0);
        check("both_inc",   32'(inc_seen), 32'd5);
        check("both_empty", 32'(bus.empty_o), 32'd1);

        do_enq(32'd10);
        do_enq(32'd20);
        do_enq(32'd30);
        check("mid_cnt3", bus.array_cnt_o, 32'd3);
        check("mid_mem2", mem[2], 32'd30);
        @(negedge clk);
        bus.enq_i      = 1'b1;
        bus.enq_data_i = 32'd5;
        @(negedge clk);
        bus.enq_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.bram_we_o) found = 1'b1;
        end
        check("mid_cmp_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_we",    32'(bus.bram_we_o), 32'd0);
        check("mid_mode",  32'(bus.mode_o), 32'd0);
        check("mid_reg",   bus.reg_out_o, 32'd0);
        check("mid_cnt",   bus.array_cnt_o, 32'd0);
        check("mid_empty", 32'(bus.empty_o), 32'd1);
        check("mid_rdy",   32'(bus.enq_rdy_o), 32'd0);
        check("mid_deq",   bus.deq_data_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_seq();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
